// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types, widths and operation codes
package calc_pkg;

  localparam int CALC_W     = 28;
  localparam int DIG_W      = 8;
  localparam int INT_DIGITS = 9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_CLR
  } calc_op_t;

  // Decimal digits needed for a w-bit magnitude: ceil(w * log10(2)).
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_display_conv.sv
// rtl/bin2bcd_display_conv.sv - sequential binary to BCD converter feeding the 7-segment driver
module bin2bcd_display_conv
  import calc_pkg::*;
#(
  parameter int WIDTH       = CALC_W,
  parameter int DISP_DIGITS = 4,
  parameter int SIGNED      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             start,
  input  logic             clr,
  output logic [DIG_W-1:0] bcd_0,
  output logic [DIG_W-1:0] bcd_1,
  output logic [DIG_W-1:0] bcd_2,
  output logic [DIG_W-1:0] bcd_3,
  output logic             neg,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int ND      = bcd_digits(WIDTH);
  localparam int BW      = ND * 4;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam int OVF_LSB = DISP_DIGITS * 4;

  conv_state_t      state;
  logic             start_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag_q;
  logic             neg_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [3:0]       disp_q [4];

  logic             launch;
  logic             neg_in;
  logic [WIDTH-1:0] mag_in;
  logic             ovf_next;

  assign launch   = start & ~start_d & (state == IDLE) & ~clr;
  assign neg_in   = (SIGNED != 0) && bin_in[WIDTH-1];
  assign mag_in   = neg_in ? (~bin_in + WIDTH'(1)) : bin_in;
  assign ovf_next = |bcd_q[BW-1:OVF_LSB];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_q[gi*4 +: 4]),
        .dout (bcd_adj[gi*4 +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_d <= 1'b0;
      cnt     <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 4; k++) disp_q[k] <= 4'd0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      if (clr) begin
        state <= IDLE;
        cnt   <= '0;
        neg   <= 1'b0;
        ovf   <= 1'b0;
        busy  <= 1'b0;
        for (int k = 0; k < 4; k++) disp_q[k] <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              mag_q <= mag_in;
              neg_q <= neg_in;
              bcd_q <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            // Correct every digit first, then shift the whole {bcd, mag} pair left by one.
            {bcd_q, mag_q} <= {bcd_adj[BW-2:0], mag_q, 1'b0};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= DONE;
            end
          end
          DONE: begin
            for (int k = 0; k < 4; k++) begin
              disp_q[k] <= (k < DISP_DIGITS) ? bcd_q[k*4 +: 4] : 4'd0;
            end
            neg   <= neg_q;
            ovf   <= ovf_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bcd_0 = {{(DIG_W-4){1'b0}}, disp_q[0]};
  assign bcd_1 = {{(DIG_W-4){1'b0}}, disp_q[1]};
  assign bcd_2 = {{(DIG_W-4){1'b0}}, disp_q[2]};
  assign bcd_3 = {{(DIG_W-4){1'b0}}, disp_q[3]};

endmodule

// File: tb/tb_bin2bcd_display_conv.sv
// tb/tb_bin2bcd_display_conv.sv - randomized self-checking bench against an arithmetic reference
module tb_bin2bcd_display_conv;

  logic        clk;
  logic        reset;
  logic [27:0] bin_in;
  logic        start;
  logic        clr;

  logic [7:0] s_b0, s_b1, s_b2, s_b3;
  logic       s_neg, s_ovf, s_busy, s_done;
  logic [7:0] u_b0, u_b1, u_b2, u_b3;
  logic       u_neg, u_ovf, u_busy, u_done;

  int checks = 0;
  int passes = 0;

  bin2bcd_display_conv #(.WIDTH(28), .DISP_DIGITS(4), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .clr(clr),
    .bcd_0(s_b0), .bcd_1(s_b1), .bcd_2(s_b2), .bcd_3(s_b3),
    .neg(s_neg), .ovf(s_ovf), .busy(s_busy), .done(s_done)
  );

  bin2bcd_display_conv #(.WIDTH(28), .DISP_DIGITS(4), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .clr(clr),
    .bcd_0(u_b0), .bcd_1(u_b1), .bcd_2(u_b2), .bcd_3(u_b3),
    .neg(u_neg), .ovf(u_ovf), .busy(u_busy), .done(u_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {neg, ovf, bcd_3, bcd_2, bcd_1, bcd_0} expected for value v.
  function automatic logic [33:0] model(input logic [27:0] v, input bit sgn);
    longint m, r;
    bit n;
    n = sgn && v[27];
    m = n ? ((longint'(1) << 28) - longint'(v)) : longint'(v);
    r = m % 10000;
    return {n, (m > 9999), 4'h0, 4'(r / 1000), 4'h0, 4'((r / 100) % 10),
            4'h0, 4'((r / 10) % 10), 4'h0, 4'(r % 10)};
  endfunction

  function automatic logic [33:0] obs_s();
    return {s_neg, s_ovf, s_b3, s_b2, s_b1, s_b0};
  endfunction

  function automatic logic [33:0] obs_u();
    return {u_neg, u_ovf, u_b3, u_b2, u_b1, u_b0};
  endfunction

  // Raise start with value v and wait for done; cyc = negedges until done (-1 on timeout).
  task automatic run_conv(input logic [27:0] v, output int cyc, output bit busy_ok);
    cyc = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bin_in = 28'($urandom);
      if (s_done) begin
        cyc = n;
        break;
      end
      if (!s_busy || !u_busy) busy_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; clr = 1'b0; bin_in = 28'd1234;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs_s(), s_busy, s_done, obs_u(), u_busy, u_done} !== '0)
      $display("FAIL reset_state: got %h/%h busy=%b done=%b, want all 0", obs_s(), obs_u(), s_busy, s_done);
    else passes++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", s_busy, s_done);
    else passes++;
  endtask

  task automatic test_conversions();
    logic [27:0] vals[$];
    int cyc;
    bit bok;
    vals = '{28'd1234, 28'hFFFFFF6, 28'd10000, 28'd9999, 28'd0, 28'h8000000,
             28'h7FFFFFF, 28'd1, 28'hFFFFFFF};
    for (int i = 0; i < 6; i++) vals.push_back(28'($urandom_range(0, 20000)));
    for (int i = 0; i < 6; i++) vals.push_back(28'($urandom));
    foreach (vals[i]) begin
      run_conv(vals[i], cyc, bok);
      checks++;
      if (cyc != 30) $display("FAIL latency v=%h: got %0d cycles, want 30", vals[i], cyc);
      else passes++;
      checks++;
      if (!bok || s_busy !== 1'b0) $display("FAIL busy_window v=%h: held=%b busy_at_done=%b, want 1 0", vals[i], bok, s_busy);
      else passes++;
      checks++;
      if (obs_s() !== model(vals[i], 1'b1))
        $display("FAIL signed_result v=%h: got %h, want %h", vals[i], obs_s(), model(vals[i], 1'b1));
      else passes++;
      checks++;
      if (obs_u() !== model(vals[i], 1'b0) || u_done !== 1'b1)
        $display("FAIL unsigned_result v=%h: got %h done=%b, want %h done=1", vals[i], obs_u(), u_done, model(vals[i], 1'b0));
      else passes++;
      @(negedge clk);
      checks++;
      if (s_done !== 1'b0 || obs_s() !== model(vals[i], 1'b1))
        $display("FAIL done_pulse_hold v=%h: done=%b out=%h, want done=0 out=%h", vals[i], s_done, obs_s(), model(vals[i], 1'b1));
      else passes++;
    end
  endtask

  task automatic test_held_start();
    int dones = 0;
    int cyc = -1;
    logic [27:0] v2;
    @(negedge clk);
    bin_in = 28'd4321;
    start  = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bin_in = 28'($urandom);
      if (n == 10) start = 1'b0;
      if (n == 11) start = 1'b1;
      if (s_done) dones++;
    end
    checks++;
    if (dones != 1) $display("FAIL held_start_dones: got %0d pulses, want 1", dones);
    else passes++;
    checks++;
    if (obs_s() !== model(28'd4321, 1'b1))
      $display("FAIL held_start_result: got %h, want %h", obs_s(), model(28'd4321, 1'b1));
    else passes++;
    start = 1'b0;
    @(negedge clk);
    v2 = 28'($urandom);
    bin_in = v2;
    start  = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bin_in = 28'($urandom);
      if (s_done) begin
        cyc = n;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (cyc != 30 || obs_s() !== model(v2, 1'b1))
      $display("FAIL relaunch v=%h: cycles=%0d out=%h, want 30 %h", v2, cyc, obs_s(), model(v2, 1'b1));
    else passes++;
  endtask

  task automatic test_clr_abort();
    int cyc;
    bit bok;
    bit bad;
    run_conv(28'(-5678), cyc, bok);
    @(negedge clk);
    bin_in = 28'd1111;
    start  = 1'b1;
    repeat (11) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || obs_s() !== '0)
      $display("FAIL clr_abort: busy=%b done=%b out=%h, want 0 0 0", s_busy, s_done, obs_s());
    else passes++;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (s_busy || s_done) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL clr_no_relaunch: busy/done seen=%b, want 0", bad);
    else passes++;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      if (s_busy || s_done) bad = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (bad) $display("FAIL clr_beats_launch: busy/done seen=%b, want 0", bad);
    else passes++;
    run_conv(28'd2468, cyc, bok);
    checks++;
    if (cyc != 30 || obs_s() !== model(28'd2468, 1'b1))
      $display("FAIL after_clr_conv: cycles=%0d out=%h, want 30 %h", cyc, obs_s(), model(28'd2468, 1'b1));
    else passes++;
  endtask

  task automatic test_reset_mid_shift();
    int cyc;
    bit bok;
    bit bad;
    run_conv(28'd9876, cyc, bok);
    @(negedge clk);
    bin_in = 28'd2222;
    start  = 1'b1;
    repeat (16) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || obs_s() !== '0)
      $display("FAIL async_reset: busy=%b done=%b out=%h, want 0 0 0", s_busy, s_done, obs_s());
    else passes++;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_busy || s_done) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL idle_after_release: busy/done seen=%b, want 0", bad);
    else passes++;
    run_conv(28'd3579, cyc, bok);
    checks++;
    if (cyc != 30 || obs_s() !== model(28'd3579, 1'b1))
      $display("FAIL after_reset_conv: cycles=%0d out=%h, want 30 %h", cyc, obs_s(), model(28'd3579, 1'b1));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_held_start();
    test_clr_abort();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
